// File: rtl/reg_write_demux_pkg.sv
// reg_write_demux_pkg
// Shared definitions for the working-register write side:
//   - register-select codes for A/B/C/D
//   - write-FSM state encoding
//   - partner() : the other half of a 16-bit register pair
package reg_write_demux_pkg;

   localparam logic [1:0] REG_A = 2'b11;
   localparam logic [1:0] REG_B = 2'b10;
   localparam logic [1:0] REG_C = 2'b00;
   localparam logic [1:0] REG_D = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      HI   = 1'b1
   } state_t;

   // Pairs are A<->B and C<->D, so the partner differs only in bit 0.
   function automatic logic [1:0] partner(input logic [1:0] sel);
      return sel ^ 2'b01;
   endfunction

endpackage

// File: rtl/reg_write_demux_if.sv
// reg_write_demux_if
// Write-beat handshake between the result bus and the register write side.
//   wr_valid : beat offered
//   wr_ready : beat accepted when wr_valid && wr_ready at a rising edge
//   wr_sel   : destination register select
//   wr_data  : 8-bit write data
//   wr_pair  : on a first beat, start a two-beat pair write
// Modports: master drives the beat, slave (the demux) returns wr_ready.
interface reg_write_demux_if;

   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_sel;
   logic [7:0] wr_data;
   logic       wr_pair;

   modport master (
      output wr_valid,
      output wr_sel,
      output wr_data,
      output wr_pair,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_sel,
      input  wr_data,
      input  wr_pair,
      output wr_ready
   );

endinterface

// File: rtl/reg_write_demux_reg_bank4.sv
// reg_bank4
// Four 8-bit working registers with a single write port and a 4:1 read mux.
//   clk, rst        : clock, synchronous active-high reset (clears to 8'h00)
//   we, wsel, wdata : write enable, destination select, write data
//   a_q..d_q        : registered contents of A/B/C/D
//   rd_sel, rd_q    : read select and selected register contents
module reg_bank4
   import reg_write_demux_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [1:0] wsel,
   input  logic [7:0] wdata,
   output logic [7:0] a_q,
   output logic [7:0] b_q,
   output logic [7:0] c_q,
   output logic [7:0] d_q,
   input  logic [1:0] rd_sel,
   output logic [7:0] rd_q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         d_q <= '0;
      end else if (we) begin
         case (wsel)
            REG_A:   a_q <= wdata;
            REG_B:   b_q <= wdata;
            REG_C:   c_q <= wdata;
            default: d_q <= wdata;
         endcase
      end
   end

   always_comb begin
      case (rd_sel)
         REG_A:   rd_q = a_q;
         REG_B:   rd_q = b_q;
         REG_C:   rd_q = c_q;
         default: rd_q = d_q;
      endcase
   end

endmodule

// File: rtl/reg_write_demux.sv
// reg_write_demux
// Write side of the 4x8-bit working-register set (A, B, C, D).
// Steers write beats into one register; a beat with wr_pair set starts a
// 16-bit pair write whose second beat goes to the partner register.  An
// unfinished pair is abandoned after PAIR_TIMEOUT idle cycles in HI (the
// first-beat write is kept).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wr           : write handshake (reg_write_demux_if.slave)
//   a_q..d_q     : registered register contents
//   rd_sel       : read select, rd_data : selected register
//   busy         : high while waiting for the second beat of a pair
//   pair_abort   : one-cycle pulse after a pair times out
// Build option: REG_WB_FWD_EN enables same-cycle forwarding of an accepted
// beat's data onto rd_data when its destination matches rd_sel.
module reg_write_demux
   import reg_write_demux_pkg::*;
#(
   parameter int unsigned PAIR_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   reg_write_demux_if.slave  wr,
   output logic [7:0]        a_q,
   output logic [7:0]        b_q,
   output logic [7:0]        c_q,
   output logic [7:0]        d_q,
   input  logic [1:0]        rd_sel,
   output logic [7:0]        rd_data,
   output logic              busy,
   output logic              pair_abort
);

   state_t     state;
   logic [7:0] timer;
   logic [1:0] partner_sel;
   logic       accept;
   logic [1:0] dest;
   logic [7:0] rd_q;

   // Both states accept beats; only reset withholds ready.
   assign wr.wr_ready = ~rst;
   assign accept      = wr.wr_valid & wr.wr_ready;
   assign dest        = (state == HI) ? partner_sel : wr.wr_sel;

   reg_bank4 u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (accept),
      .wsel   (dest),
      .wdata  (wr.wr_data),
      .a_q    (a_q),
      .b_q    (b_q),
      .c_q    (c_q),
      .d_q    (d_q),
      .rd_sel (rd_sel),
      .rd_q   (rd_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         timer       <= '0;
         partner_sel <= '0;
         busy        <= 1'b0;
         pair_abort  <= 1'b0;
      end else begin
         pair_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && wr.wr_pair) begin
                  partner_sel <= partner(wr.wr_sel);
                  timer       <= '0;
                  state       <= HI;
                  busy        <= 1'b1;
               end
            end
            HI: begin
               // A beat in the cycle the timer sits at the limit still wins.
               if (accept) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (timer == 8'(PAIR_TIMEOUT)) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  pair_abort <= 1'b1;
               end else if (timer != '1) begin
                  timer <= timer + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef REG_WB_FWD_EN
   always_comb begin
      rd_data = rd_q;
      if (accept && (dest == rd_sel))
         rd_data = wr.wr_data;
   end
`else
   assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_reg_write_demux.sv
// tb_reg_write_demux
// Directed bench for reg_write_demux with hand-computed expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_reg_write_demux;

   logic       clk;
   logic       rst;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;
   logic [7:0] a_q, b_q, c_q, d_q;
   logic       busy;
   logic       pair_abort;

   int checks;
   int failures;

   reg_write_demux_if bus ();

   reg_write_demux #(.PAIR_TIMEOUT(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr         (bus.slave),
      .a_q        (a_q),
      .b_q        (b_q),
      .c_q        (c_q),
      .d_q        (d_q),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .busy       (busy),
      .pair_abort (pair_abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] sel, input logic [7:0] data, input logic pair);
      bus.wr_valid = 1'b1;
      bus.wr_sel   = sel;
      bus.wr_data  = data;
      bus.wr_pair  = pair;
   endtask

   task automatic idle();
      bus.wr_valid = 1'b0;
      bus.wr_pair  = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      rd_sel   = 2'b00;
      // A beat offered during reset must not land.
      beat(2'b00, 8'hFF, 1'b0);
      step();
      #1;
      check_eq("ready_in_reset", 32'(bus.wr_ready), 32'd0);
      step();
      idle();
      check_eq("rst_a", 32'(a_q), 32'h00);
      check_eq("rst_b", 32'(b_q), 32'h00);
      check_eq("rst_c", 32'(c_q), 32'h00);
      check_eq("rst_d", 32'(d_q), 32'h00);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_abort", 32'(pair_abort), 32'd0);
      rst = 1'b0;
      #1;
      check_eq("ready_idle", 32'(bus.wr_ready), 32'd1);

      // Single write to C.
      beat(2'b00, 8'h5A, 1'b0);
      step();
      idle();
      rd_sel = 2'b00;
      #1;
      check_eq("single_c", 32'(c_q), 32'h5A);
      check_eq("single_a", 32'(a_q), 32'h00);
      check_eq("single_b", 32'(b_q), 32'h00);
      check_eq("single_d", 32'(d_q), 32'h00);
      check_eq("single_rd", 32'(rd_data), 32'h5A);
      check_eq("single_busy", 32'(busy), 32'd0);

      // Pair write A then partner B; wr_sel/wr_pair of beat 2 ignored.
      beat(2'b11, 8'h34, 1'b1);
      step();
      check_eq("pair1_a", 32'(a_q), 32'h34);
      check_eq("pair1_busy", 32'(busy), 32'd1);
      check_eq("pair1_ready", 32'(bus.wr_ready), 32'd1);
      beat(2'b00, 8'h12, 1'b1);
      step();
      idle();
      check_eq("pair2_b", 32'(b_q), 32'h12);
      check_eq("pair2_c", 32'(c_q), 32'h5A);
      check_eq("pair2_a", 32'(a_q), 32'h34);
      check_eq("pair2_busy", 32'(busy), 32'd0);

      // Timeout: pair on D, no second beat.
      beat(2'b01, 8'h77, 1'b1);
      step();
      idle();
      check_eq("to_d", 32'(d_q), 32'h77);
      check_eq("to_busy_start", 32'(busy), 32'd1);
      for (int i = 0; i < 15; i++) begin
         step();
         check_eq($sformatf("to_wait_busy%0d", i), 32'(busy), 32'd1);
         check_eq($sformatf("to_wait_abort%0d", i), 32'(pair_abort), 32'd0);
      end
      step();
      check_eq("to_abort", 32'(pair_abort), 32'd1);
      check_eq("to_busy_drop", 32'(busy), 32'd0);
      check_eq("to_d_kept", 32'(d_q), 32'h77);
      check_eq("to_c_kept", 32'(c_q), 32'h5A);
      // Back in IDLE: a write to A lands in A, not in partner C.
      beat(2'b11, 8'hAB, 1'b0);
      step();
      idle();
      check_eq("to_abort_pulse", 32'(pair_abort), 32'd0);
      check_eq("to_idle_a", 32'(a_q), 32'hAB);
      check_eq("to_idle_c", 32'(c_q), 32'h5A);

      // Edge of timeout: second beat in the cycle the timer sits at 15.
      beat(2'b00, 8'h11, 1'b1);
      step();
      idle();
      for (int i = 0; i < 15; i++) step();
      check_eq("edge_busy", 32'(busy), 32'd1);
      beat(2'b11, 8'h99, 1'b1);
      step();
      idle();
      check_eq("edge_d", 32'(d_q), 32'h99);
      check_eq("edge_c", 32'(c_q), 32'h11);
      check_eq("edge_a", 32'(a_q), 32'hAB);
      check_eq("edge_abort", 32'(pair_abort), 32'd0);
      check_eq("edge_busy_drop", 32'(busy), 32'd0);
      step();
      check_eq("edge_abort_late", 32'(pair_abort), 32'd0);

      // Reset while in HI.
      beat(2'b10, 8'h42, 1'b1);
      step();
      idle();
      check_eq("rhi_b", 32'(b_q), 32'h42);
      check_eq("rhi_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rhi_a", 32'(a_q), 32'h00);
      check_eq("rhi_b0", 32'(b_q), 32'h00);
      check_eq("rhi_c", 32'(c_q), 32'h00);
      check_eq("rhi_d", 32'(d_q), 32'h00);
      check_eq("rhi_busy0", 32'(busy), 32'd0);
      check_eq("rhi_abort", 32'(pair_abort), 32'd0);
      beat(2'b10, 8'h55, 1'b0);
      step();
      idle();
      check_eq("rhi_next_b", 32'(b_q), 32'h55);
      check_eq("rhi_next_a", 32'(a_q), 32'h00);
      check_eq("rhi_next_busy", 32'(busy), 32'd0);
      check_eq("rhi_next_abort", 32'(pair_abort), 32'd0);

      // Forwarding of an accepted beat onto rd_data.
      rd_sel = 2'b10;
      beat(2'b10, 8'hC3, 1'b0);
      #1;
`ifdef REG_WB_FWD_EN
      check_eq("fwd_same_cycle", 32'(rd_data), 32'hC3);
`else
      check_eq("fwd_same_cycle", 32'(rd_data), 32'h55);
`endif
      rd_sel = 2'b11;
      #1;
      check_eq("fwd_other_sel", 32'(rd_data), 32'h00);
      rd_sel = 2'b10;
      step();
      idle();
      check_eq("fwd_b", 32'(b_q), 32'hC3);
      check_eq("fwd_rd_after", 32'(rd_data), 32'hC3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
